simd_shader_processor: RTL and testbench
========================================

// Module: simd_shader_processor
// PURPOSE
//   Minimal 4-lane SIMD shader core. Each cycle it fetches one instruction from an internal
//   16-entry program ROM, applies one ALU op (ADD/MUL/AND/OR) to every lane enabled by the
//   instruction mask, and writes back per-lane accumulators. Top-level demo/debug block.
//   Exposes PC, decode fields, the lane result and all lane registers for observation.
// PARAMETERS
//   DATA_W     32  lane register / result width
//   NUM_LANES  4   SIMD lanes (fixed at 4; mask and reg outputs sized for 4)
//   PROG_LEN   16  ROM depth; PC width = 4
// PORTS
//   clk             in   1   single clock, all state on rising edge
//   rst             in   1   synchronous, active-low reset (sampled on clk rising edge)
//   current_pc      out  4   PC of instruction currently being executed
//   current_result  out  32  ALU result of the lowest-numbered enabled lane; 0 if mask==0
//   current_op      out  2   op of current instr: 00 ADD, 01 MUL, 10 AND, 11 OR
//   current_mask    out  4   lane enable mask of current instr (bit i = lane i)
//   reg0_value..reg3_value  out  32 each  lane 0..3 accumulator register contents
// BEHAVIOUR
//   - Instr word 16b: [15:14] op, [13:10] mask, [9:8] reserved(0), [7:0] imm.
//   - Lane i operand = zero-extend(imm) + i (32-bit); lane i result = reg_i OP operand_i.
//   - ADD: mod 2^32. MUL: low 32 bits of 64-bit product. AND/OR: bitwise.
//   - Rising edge with rst==1: for each i with mask[i]==1, reg_i <= result_i; masked-off
//     lanes hold. PC <= PC+1, wraps 15 -> 0. One instruction per cycle, no stalls.
//   - Rising edge with rst==0: PC <= 0, reg_i <= i (0,1,2,3). Overrides any execution,
//     including mid-program; no write-back happens on that edge.
//   - current_pc/op/mask/result are combinational from PC, ROM and regs (preview of the
//     write-back that occurs on the next edge). Reset values: pc 0, op 00, mask 1111,
//     result 1, regs 0/1/2/3 (i.e. decode of ROM[0] against reset regs).
//   - ROM contents (op mask imm): 0 ADD 1111 01; 1 MUL 1111 02; 2 AND 0101 0F;
//     3 OR 1010 80; 4 ADD 0011 10; 5 MUL 1100 03; 6 ADD 0000 FF (NOP); 7 OR 1111 01;
//     entries 8-15 duplicate entries 0-7.
//   - mask==0000: no register changes, current_result = 0, PC still advances.
//   - No X on outputs after first reset edge; ROM is constant (synthesizes to LUT).
// TESTING
//   - Reset: hold rst=0 2 edges -> pc 0, regs 0/1/2/3, op ADD, mask 1111, result 1.
//   - Release rst, 1 edge (PC0 ADD) -> regs 1/3/5/7, pc 1, op MUL, result 2.
//   - Next edge (PC1 MUL) -> regs 2/9/20/35; next (PC2 AND 0101) -> regs 2/9/16/35.
//   - PC6 mask 0000 -> current_result 0, regs unchanged across that edge.
//   - Run 16 edges from reset -> pc wraps to 0, then PC8 behaves exactly as PC0 op/mask/imm.
//   - Assert rst=0 at PC5 -> next edge pc 0, regs 0/1/2/3, no PC5 write-back.

Source files
------------

// File: rtl/simd_shader_processor.sv
// simd_shader_processor
//   Minimal 4-lane SIMD shader core for demo/debug use. Every cycle one
//   instruction is fetched from a constant 16-entry program ROM, one ALU op
//   (ADD/MUL/AND/OR) is applied to each lane enabled by the instruction mask,
//   and the enabled lane accumulators are written back. The PC then advances
//   and wraps from 15 to 0.
//
// Ports
//   clk             : single clock, all state updates on the rising edge
//   rst             : synchronous active-low reset
//   current_pc      : PC of the instruction being executed this cycle
//   current_result  : ALU result of the lowest-numbered enabled lane (0 if mask is 0)
//   current_op      : op of the current instruction (00 ADD, 01 MUL, 10 AND, 11 OR)
//   current_mask    : lane enable mask of the current instruction (bit i = lane i)
//   reg0_value..reg3_value : lane 0..3 accumulator contents
//
// The current_* outputs are combinational and preview the write-back that
// will happen on the next rising edge.

module simd_shader_processor #(
   parameter int DATA_W    = 32,
   parameter int NUM_LANES = 4,
   parameter int PROG_LEN  = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [3:0]        current_pc,
   output logic [DATA_W-1:0] current_result,
   output logic [1:0]        current_op,
   output logic [3:0]        current_mask,
   output logic [DATA_W-1:0] reg0_value,
   output logic [DATA_W-1:0] reg1_value,
   output logic [DATA_W-1:0] reg2_value,
   output logic [DATA_W-1:0] reg3_value
);

   localparam int PC_W = $clog2(PROG_LEN);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   // The instruction word is {op[1:0], mask[3:0], reserved[1:0], imm[7:0]}.
   // The reserved bits are always zero, so the ROM stores only the
   // meaningful fields as {op, mask, imm}. Entries 8-15 repeat 0-7, hence
   // only the low three address bits select the entry.
   function automatic logic [13:0] rom_fetch(input logic [PC_W-1:0] addr);
      logic [13:0] entry;
      case (addr[2:0])
         3'd0:    entry = {OP_ADD, 4'b1111, 8'h01};
         3'd1:    entry = {OP_MUL, 4'b1111, 8'h02};
         3'd2:    entry = {OP_AND, 4'b0101, 8'h0F};
         3'd3:    entry = {OP_OR,  4'b1010, 8'h80};
         3'd4:    entry = {OP_ADD, 4'b0011, 8'h10};
         3'd5:    entry = {OP_MUL, 4'b1100, 8'h03};
         3'd6:    entry = {OP_ADD, 4'b0000, 8'hFF};
         default: entry = {OP_OR,  4'b1111, 8'h01};
      endcase
      return entry;
   endfunction

   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] lane_q [NUM_LANES];
   logic [DATA_W-1:0] lane_d [NUM_LANES];

   logic [13:0]       instr;
   op_e               op;
   logic [3:0]        mask;
   logic [7:0]        imm;
   logic [DATA_W-1:0] operand [NUM_LANES];
   logic [DATA_W-1:0] lane_result [NUM_LANES];

   // Decode the instruction at the current PC.
   always_comb begin
      instr = rom_fetch(pc_q);
      op    = op_e'(instr[13:12]);
      mask  = instr[11:8];
      imm   = instr[7:0];
   end

   // Per-lane ALU. Each lane sees the immediate offset by its lane index so
   // lanes diverge even when running the same instruction. MUL keeps only
   // the low DATA_W bits of the product, which the DATA_W-wide context gives.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         operand[i] = {{(DATA_W-8){1'b0}}, imm} + DATA_W'(i);
         case (op)
            OP_ADD:  lane_result[i] = lane_q[i] + operand[i];
            OP_MUL:  lane_result[i] = lane_q[i] * operand[i];
            OP_AND:  lane_result[i] = lane_q[i] & operand[i];
            default: lane_result[i] = lane_q[i] | operand[i];
         endcase
      end
   end

   // Next-state: enabled lanes take their ALU result, masked-off lanes hold,
   // and the PC always advances (natural wrap at the PC width).
   always_comb begin
      pc_d = pc_q + 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_d[i] = lane_q[i];
         if (mask[i]) begin
            lane_d[i] = lane_result[i];
         end
      end
   end

   // Observation result: scan from the highest lane down so the lowest
   // enabled lane wins; an all-zero mask leaves the default of zero.
   always_comb begin
      current_result = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            current_result = lane_result[i];
         end
      end
   end

   // State registers. Reset seeds each lane with its own index and takes
   // priority over any write-back scheduled for the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            lane_q[i] <= DATA_W'(i);
         end
      end else begin
         pc_q <= pc_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            lane_q[i] <= lane_d[i];
         end
      end
   end

   assign current_pc   = pc_q;
   assign current_op   = op;
   assign current_mask = mask;
   assign reg0_value   = lane_q[0];
   assign reg1_value   = lane_q[1];
   assign reg2_value   = lane_q[2];
   assign reg3_value   = lane_q[3];

endmodule

// File: tb/tb_simd_shader_processor.sv
// Directed testbench for simd_shader_processor. Expected lane values are
// hand-computed from the program ROM contents and the lane operand rule
// (operand_i = imm + i).

module tb_simd_shader_processor;

   logic        clk;
   logic        rst;
   logic [3:0]  current_pc;
   logic [31:0] current_result;
   logic [1:0]  current_op;
   logic [3:0]  current_mask;
   logic [31:0] reg0_value;
   logic [31:0] reg1_value;
   logic [31:0] reg2_value;
   logic [31:0] reg3_value;

   int total;
   int bad;

   logic [31:0] regs_obs [4];

   simd_shader_processor dut (
      .clk            (clk),
      .rst            (rst),
      .current_pc     (current_pc),
      .current_result (current_result),
      .current_op     (current_op),
      .current_mask   (current_mask),
      .reg0_value     (reg0_value),
      .reg1_value     (reg1_value),
      .reg2_value     (reg2_value),
      .reg3_value     (reg3_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign regs_obs[0] = reg0_value;
   assign regs_obs[1] = reg1_value;
   assign regs_obs[2] = reg2_value;
   assign regs_obs[3] = reg3_value;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_regs [4];
      exp_regs = '{32'd0, 32'd1, 32'd2, 32'd3};
      rst = 1'b0;
      step();
      step();
      total++;
      if (current_pc !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_pc got=%0d want=0", current_pc);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (regs_obs[i] !== exp_regs[i]) begin
            bad++;
            $display("[TB] FAIL reset_reg%0d got=%0d want=%0d", i, regs_obs[i], exp_regs[i]);
         end
      end
      total++;
      if (current_op !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_op got=%b want=00", current_op);
      end
      total++;
      if (current_mask !== 4'b1111) begin
         bad++;
         $display("[TB] FAIL reset_mask got=%b want=1111", current_mask);
      end
      total++;
      if (current_result !== 32'd1) begin
         bad++;
         $display("[TB] FAIL reset_result got=%0d want=1", current_result);
      end
   endtask

   // Runs PC0..PC8 from reset. Each row: regs after the edge, then the
   // preview (pc, op, mask, result) of the next instruction.
   task automatic test_program();
      logic [31:0] exp_regs [9][4];
      logic [3:0]  exp_pc   [9];
      logic [1:0]  exp_op   [9];
      logic [3:0]  exp_mask [9];
      logic [31:0] exp_res  [9];
      exp_regs[0] = '{32'd1,  32'd3,   32'd5,  32'd7};
      exp_regs[1] = '{32'd2,  32'd9,   32'd20, 32'd35};
      exp_regs[2] = '{32'd2,  32'd9,   32'd16, 32'd35};
      exp_regs[3] = '{32'd2,  32'd137, 32'd16, 32'd163};
      exp_regs[4] = '{32'd18, 32'd154, 32'd16, 32'd163};
      exp_regs[5] = '{32'd18, 32'd154, 32'd80, 32'd978};
      exp_regs[6] = '{32'd18, 32'd154, 32'd80, 32'd978};
      exp_regs[7] = '{32'd19, 32'd154, 32'd83, 32'd982};
      exp_regs[8] = '{32'd20, 32'd156, 32'd86, 32'd986};
      exp_pc   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
      exp_op   = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01};
      exp_mask = '{4'b1111, 4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b0000,
                   4'b1111, 4'b1111, 4'b1111};
      exp_res  = '{32'd2, 32'd2, 32'd137, 32'd18, 32'd80, 32'd0, 32'd19, 32'd20, 32'd40};
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int s = 0; s < 9; s++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            total++;
            if (regs_obs[i] !== exp_regs[s][i]) begin
               bad++;
               $display("[TB] FAIL prog_pc%0d_reg%0d got=%0d want=%0d",
                        s, i, regs_obs[i], exp_regs[s][i]);
            end
         end
         total++;
         if (current_pc !== exp_pc[s]) begin
            bad++;
            $display("[TB] FAIL prog_step%0d_pc got=%0d want=%0d", s, current_pc, exp_pc[s]);
         end
         total++;
         if (current_op !== exp_op[s]) begin
            bad++;
            $display("[TB] FAIL prog_step%0d_op got=%b want=%b", s, current_op, exp_op[s]);
         end
         total++;
         if (current_mask !== exp_mask[s]) begin
            bad++;
            $display("[TB] FAIL prog_step%0d_mask got=%b want=%b", s, current_mask, exp_mask[s]);
         end
         total++;
         if (current_result !== exp_res[s]) begin
            bad++;
            $display("[TB] FAIL prog_step%0d_result got=%0d want=%0d",
                     s, current_result, exp_res[s]);
         end
      end
   endtask

   task automatic test_wrap();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int s = 0; s < 16; s++) begin
         step();
      end
      total++;
      if (current_pc !== 4'd0) begin
         bad++;
         $display("[TB] FAIL wrap_pc got=%0d want=0", current_pc);
      end
      total++;
      if (current_op !== 2'b00 || current_mask !== 4'b1111) begin
         bad++;
         $display("[TB] FAIL wrap_decode got=%b/%b want=00/1111", current_op, current_mask);
      end
   endtask

   task automatic test_reset_mid_program();
      logic [31:0] exp_rst [4];
      logic [31:0] exp_run [4];
      exp_rst = '{32'd0, 32'd1, 32'd2, 32'd3};
      exp_run = '{32'd1, 32'd3, 32'd5, 32'd7};
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int s = 0; s < 5; s++) begin
         step();
      end
      total++;
      if (current_pc !== 4'd5) begin
         bad++;
         $display("[TB] FAIL midrst_reach_pc got=%0d want=5", current_pc);
      end
      rst = 1'b0;
      step();
      total++;
      if (current_pc !== 4'd0) begin
         bad++;
         $display("[TB] FAIL midrst_pc got=%0d want=0", current_pc);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (regs_obs[i] !== exp_rst[i]) begin
            bad++;
            $display("[TB] FAIL midrst_reg%0d got=%0d want=%0d", i, regs_obs[i], exp_rst[i]);
         end
      end
      total++;
      if (current_result !== 32'd1) begin
         bad++;
         $display("[TB] FAIL midrst_result got=%0d want=1", current_result);
      end
      rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (regs_obs[i] !== exp_run[i]) begin
            bad++;
            $display("[TB] FAIL midrst_restart_reg%0d got=%0d want=%0d",
                     i, regs_obs[i], exp_run[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      test_reset();
      test_program();
      test_wrap();
      test_reset_mid_program();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
